mem_arbiter: RTL

// - Shares the single cacheline-granular physical memory path (cacheline adaptor -> burst port) between icache and dcache.
// - Sits between the two caches and the cacheline adaptor inside mp4 top.
// - Serialises misses and write-backs: exactly one transaction is outstanding at a time.
// - Steers the adaptor response back to the owning cache.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single cacheline memory path (cacheline adaptor)
//               between icache and dcache. One transaction is in flight at a
//               time, and the adaptor response is steered back to the cache
//               that owns it. By default dcache has fixed priority over
//               icache. Defining MEM_ARB_RR_EN selects round-robin
//               arbitration when both caches request at once.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // icache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // dcache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // cacheline adaptor side
  output logic              ca_read,
  output logic              ca_write,
  output logic [ADDR_W-1:0] ca_addr,
  output logic [LINE_W-1:0] ca_wdata,
  input  logic [LINE_W-1:0] ca_rdata,
  input  logic              ca_resp,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q;
  logic                ca_read_q;
  logic                ca_write_q;
  logic [ADDR_W-1:0]   ca_addr_q;
  logic [LINE_W-1:0]   ca_wdata_q;
  logic                d_req;
  logic                pick_d;

`ifdef MEM_ARB_RR_EN
  // Side granted most recently: 0 = icache, 1 = dcache
  logic                last_grant_q;
`endif

  assign d_req = d_read | d_write;

  // Choose dcache when it requests, subject to the contention policy
  always_comb begin
    pick_d = d_req;
`ifdef MEM_ARB_RR_EN
    if (d_req && i_read) begin
      pick_d = ~last_grant_q;
    end
`endif
  end

  // Transaction FSM: grant, hold the latched request until ca_resp, one dead cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ca_read_q    <= 1'b0;
      ca_write_q   <= 1'b0;
      ca_addr_q    <= '0;
      ca_wdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            // Write wins if a cache raises read and write together
            state_q      <= SERVE_D;
            ca_write_q   <= d_write;
            ca_read_q    <= ~d_write;
            ca_addr_q    <= d_addr;
            ca_wdata_q   <= d_wdata;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
          end else if (i_read) begin
            // icache only ever fills
            state_q      <= SERVE_I;
            ca_read_q    <= 1'b1;
            ca_write_q   <= 1'b0;
            ca_addr_q    <= i_addr;
            ca_wdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (ca_resp) begin
            state_q    <= DONE;
            ca_read_q  <= 1'b0;
            ca_write_q <= 1'b0;
          end
        end
        DONE: begin
          // Requests are not sampled here so the owner can drop its request
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ca_read  = ca_read_q;
  assign ca_write = ca_write_q;
  assign ca_addr  = ca_addr_q;
  assign ca_wdata = ca_wdata_q;

  // Completion goes only to the owner, in the same cycle as ca_resp
  assign i_resp  = (state_q == SERVE_I) & ca_resp;
  assign d_resp  = (state_q == SERVE_D) & ca_resp;
  assign i_rdata = ca_rdata;
  assign d_rdata = ca_rdata;
  assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire
